// File: rtl/blockmem_pkg.sv
// Shared types and block helpers for the blockmem_arb memory model.
// The write-mask feature is selected by BLOCKMEM_WMASK_EN (see blockmem_arb).
package blockmem_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    localparam int WORD_W_DEF      = 16;
    localparam int BLOCK_WORDS_DEF = 4;
    localparam int BLOCK_W         = BLOCK_WORDS_DEF * WORD_W_DEF;
    localparam int OFFS_W          = $clog2(BLOCK_WORDS_DEF);

    // Helpers work on a wide container so any block geometry up to MAX_BLK_W fits.
    localparam int MAX_BLK_W = 1024;
    typedef logic [MAX_BLK_W-1:0] blk_t;

    function automatic blk_t blk_word(input blk_t blk, input int idx, input int word_w);
        blk_t m;
        m = (blk_t'(1) << word_w) - blk_t'(1);
        return (blk >> (idx * word_w)) & m;
    endfunction

    function automatic blk_t blk_put(input blk_t blk, input int idx, input int word_w,
                                     input blk_t word);
        blk_t m;
        m = ((blk_t'(1) << word_w) - blk_t'(1)) << (idx * word_w);
        return (blk & ~m) | ((word << (idx * word_w)) & m);
    endfunction

endpackage

// File: rtl/blockmem_rr_arbiter.sv
// Combinational round-robin pick: first requesting port at or after rr_ptr_i.
module blockmem_rr_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [PTR_W-1:0]     rr_ptr_i,
    output logic [PTR_W-1:0]     gnt_o,
    output logic                 vld_o
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] cand;

    // Scan from farthest to nearest so the nearest requester overwrites the result.
    always_comb begin
        gnt_o = '0;
        vld_o = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr_i} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_PORTS)) sum = sum - (PTR_W+1)'(NUM_PORTS);
            cand = sum[PTR_W-1:0];
            if (req_i[cand]) begin
                gnt_o = cand;
                vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/blockmem_arb.sv
// Multi-port block memory model with fixed latency and round-robin arbitration.
// Define BLOCKMEM_WMASK_EN to honour the per-word write mask on block writes.
module blockmem_arb
    import blockmem_pkg::*;
#(
    parameter int WORD_W      = 16,
    parameter int BLOCK_WORDS = 4,
    parameter int ADDR_W      = 8,
    parameter int NUM_PORTS   = 2,
    parameter int LATENCY     = 4
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic [NUM_PORTS-1:0]                    req_i,
    input  logic [NUM_PORTS-1:0]                    we_i,
    input  logic [NUM_PORTS*ADDR_W-1:0]             addr_i,
    input  logic [NUM_PORTS*BLOCK_WORDS*WORD_W-1:0] wdata_i,
    input  logic [NUM_PORTS*BLOCK_WORDS-1:0]        wmask_i,
    output logic [NUM_PORTS*BLOCK_WORDS*WORD_W-1:0] rdata_o,
    output logic [NUM_PORTS-1:0]                    ack_o,
    output logic                                    busy_o
);

    localparam int BW    = BLOCK_WORDS * WORD_W;
    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PTR_W-1:0]        gnt_q, gnt_d, rr_q, rr_d;
    logic [ADDR_W-1:0]       baddr_q, baddr_d;
    logic [NUM_PORTS-1:0]    ack_q, ack_d;
    logic [NUM_PORTS*BW-1:0] rdata_q, rdata_d;
    logic [WORD_W-1:0]       mem_q [2**ADDR_W];

    logic [PTR_W-1:0]       arb_gnt;
    logic                   arb_vld;
    logic [ADDR_W-1:0]      sel_base;
    logic [BW-1:0]          sel_wdata;
    logic [BLOCK_WORDS-1:0] sel_mask, wr_mask;
    logic                   wr_en;
    logic [BW-1:0]          rd_blk;

    blockmem_rr_arbiter #(.NUM_PORTS(NUM_PORTS), .PTR_W(PTR_W)) u_arb (
        .req_i    (req_i),
        .rr_ptr_i (rr_q),
        .gnt_o    (arb_gnt),
        .vld_o    (arb_vld)
    );

    assign sel_base  = addr_i[arb_gnt*ADDR_W +: ADDR_W] & ~ADDR_W'(BLOCK_WORDS - 1);
    assign sel_wdata = wdata_i[arb_gnt*BW +: BW];
    assign sel_mask  = wmask_i[arb_gnt*BLOCK_WORDS +: BLOCK_WORDS];

`ifdef BLOCKMEM_WMASK_EN
    assign wr_mask = sel_mask;
`else
    // Mask is ignored: every word of the block is written.
    assign wr_mask = sel_mask | {BLOCK_WORDS{1'b1}};
`endif

    // Writes commit on the grant edge, so the later read returns merged data.
    assign wr_en = reset_n && (state_q == IDLE) && arb_vld && we_i[arb_gnt];

    always_ff @(posedge clk) begin
        for (int i = 0; i < BLOCK_WORDS; i++) begin
            if (wr_en && wr_mask[i])
                mem_q[sel_base | ADDR_W'(i)] <= WORD_W'(blk_word(blk_t'(sel_wdata), i, WORD_W));
        end
    end

    always_comb begin
        rd_blk = '0;
        for (int i = 0; i < BLOCK_WORDS; i++)
            rd_blk = BW'(blk_put(blk_t'(rd_blk), i, WORD_W, blk_t'(mem_q[baddr_q | ADDR_W'(i)])));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        baddr_d = baddr_q;
        ack_d   = '0;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    gnt_d   = arb_gnt;
                    baddr_d = sel_base;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    rdata_d[gnt_q*BW +: BW] = rd_blk;
                    ack_d[gnt_q]            = 1'b1;
                    rr_d    = (gnt_q == PTR_W'(NUM_PORTS - 1)) ? '0 : PTR_W'(gnt_q + 1'b1);
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gnt_q   <= '0;
            rr_q    <= '0;
            baddr_q <= '0;
            ack_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            baddr_q <= baddr_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;
    assign ack_o   = ack_q;
    assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_blockmem_arb.sv
// Scoreboard bench for blockmem_arb: expected blocks are queued at issue, checked on ack.
module tb_blockmem_arb;

    localparam int AW = 8;
    localparam int NP = 2;
    localparam int BW = 64;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [NP-1:0]    req, we, ack;
    logic [NP*AW-1:0] addr;
    logic [NP*BW-1:0] wdata, rdata;
    logic [NP*4-1:0]  wmask;
    logic             busy;

    logic        r1_req, r1_we, r1_ack, r1_busy;
    logic [7:0]  r1_addr;
    logic [63:0] r1_wdata, r1_rdata;
    logic [3:0]  r1_wmask;

    blockmem_arb #(.WORD_W(16), .BLOCK_WORDS(4), .ADDR_W(AW), .NUM_PORTS(NP), .LATENCY(4)) dut (
        .clk(clk), .reset_n(reset_n), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .wmask_i(wmask), .rdata_o(rdata), .ack_o(ack), .busy_o(busy)
    );

    blockmem_arb #(.WORD_W(16), .BLOCK_WORDS(4), .ADDR_W(8), .NUM_PORTS(1), .LATENCY(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .req_i(r1_req), .we_i(r1_we), .addr_i(r1_addr),
        .wdata_i(r1_wdata), .wmask_i(r1_wmask), .rdata_o(r1_rdata), .ack_o(r1_ack), .busy_o(r1_busy)
    );

    typedef struct {
        int          port;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0, n_pass = 0;
    int   cyc = 0;
    int   ack_cyc[NP];

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    endtask

    // Monitor: every ack must match the oldest expected response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                if (ack[p]) begin
                    ack_cyc[p] = cyc;
                    if (sb.size() == 0) begin
                        chk("unexpected_ack_port", 128'(p), 128'(99));
                    end else begin
                        e = sb.pop_front();
                        chk("ack_port", 128'(p), 128'(e.port));
                        chk("rdata", 128'(rdata[p*BW +: BW]), 128'(e.data));
                    end
                end
            end
        end
    end

    task automatic issue(input int p, input logic w, input logic [7:0] a,
                         input logic [63:0] d, input logic [3:0] m, output int lat);
        @(negedge clk);
        we[p] = w;
        addr[p*AW +: AW] = a;
        wdata[p*BW +: BW] = d;
        wmask[p*4 +: 4] = m;
        req[p] = 1'b1;
        lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (ack[p]) break;
            if (lat > 40) begin
                chk("ack_timeout_cycles", 128'(lat), 128'(0));
                break;
            end
        end
        req[p] = 1'b0;
    endtask

    task automatic txn(input int p, input logic w, input logic [7:0] a,
                       input logic [63:0] d, input logic [3:0] m, input logic [63:0] expd);
        int lat;
        sb.push_back('{p, expd});
        issue(p, w, a, d, m, lat);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rdata_after_reset", 128'(rdata), 128'(0));
        reset_n = 1'b1;
    endtask

    localparam logic [63:0] BLK_A = 64'h00A3_00A2_00A1_00A0;
    localparam logic [63:0] BLK_B = 64'h4444_3333_2222_1111;
    localparam logic [63:0] BLK_D = 64'hDEAD_BEEF_1234_5678;
    localparam logic [63:0] BLK_E = 64'h0123_4567_89AB_CDEF;
`ifdef BLOCKMEM_WMASK_EN
    localparam logic [63:0] BLK_M = 64'h0000_FFFF_0000_FFFF;
`else
    localparam logic [63:0] BLK_M = 64'hFFFF_FFFF_FFFF_FFFF;
`endif

    initial begin
        int lat, t0a;
        int acks[$];
        req = '0; we = '0; addr = '0; wdata = '0; wmask = '0;
        r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0; r1_wmask = '0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ack", 128'(ack), 128'(0));
        chk("reset_busy", 128'(busy), 128'(0));
        chk("reset_rdata", 128'(rdata), 128'(0));
        chk("reset_rdata_lat1", 128'(r1_rdata), 128'(0));
        reset_n = 1'b1;

        // Preload 0x20..0x23, then reset: memory must survive.
        txn(0, 1'b1, 8'h20, BLK_A, 4'hF, BLK_A);
        pulse_reset();

        sb.push_back('{0, BLK_A});
        issue(0, 1'b0, 8'h22, 64'h0, 4'h0, lat);
        chk("read_latency_cycles", 128'(lat), 128'(5));

        txn(1, 1'b1, 8'h41, BLK_B, 4'hF, BLK_B);
        txn(0, 1'b0, 8'h43, 64'h0, 4'h0, BLK_B);

        // Contention: p0 wins after reset, p1 next, then p1 before p0's re-request.
        pulse_reset();
        sb.push_back('{0, BLK_A});
        sb.push_back('{1, BLK_B});
        sb.push_back('{0, BLK_B});
        fork
            begin
                int l0;
                issue(0, 1'b0, 8'h20, 64'h0, 4'h0, l0);
                t0a = cyc;
                issue(0, 1'b0, 8'h42, 64'h0, 4'h0, l0);
            end
            begin
                int l1;
                issue(1, 1'b0, 8'h40, 64'h0, 4'h0, l1);
            end
        join
        chk("p1_ack_gap_after_p0", 128'(ack_cyc[1] - t0a), 128'(6));
        chk("p0_ack_gap_after_p1", 128'(ack_cyc[0] - ack_cyc[1]), 128'(6));

        txn(0, 1'b1, 8'h40, 64'h0, 4'hF, 64'h0);
        txn(1, 1'b1, 8'h40, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0101, BLK_M);

        // Abort: reset two cycles after a write grant; the write stays.
        @(negedge clk);
        we[0] = 1'b1; addr[0 +: AW] = 8'h60; wdata[0 +: BW] = BLK_D; wmask[0 +: 4] = 4'hF;
        req[0] = 1'b1;
        @(negedge clk);
        chk("busy_after_grant", 128'(busy), 128'(1));
        @(negedge clk);
        reset_n = 1'b0;
        req[0] = 1'b0;
        @(negedge clk);
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_ack", 128'(ack), 128'(0));
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        txn(0, 1'b0, 8'h61, 64'h0, 4'h0, BLK_D);

        // LATENCY=1 instance with req held: one ack every 3 cycles.
        @(negedge clk);
        r1_we = 1'b1; r1_addr = 8'h10; r1_wdata = BLK_E; r1_wmask = 4'hF; r1_req = 1'b1;
        for (int i = 0; i < 40 && acks.size() < 4; i++) begin
            @(negedge clk);
            if (r1_ack) begin
                acks.push_back(cyc);
                chk("lat1_rdata", 128'(r1_rdata), 128'(BLK_E));
            end
        end
        r1_req = 1'b0;
        chk("lat1_ack_count", 128'(acks.size()), 128'(4));
        for (int i = 1; i < acks.size(); i++)
            chk("lat1_ack_interval", 128'(acks[i] - acks[i-1]), 128'(3));

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 128'(sb.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule

// File: doc/blockmem_arb.md
# blockmem_arb

Parametrised, multi-port, block-granular main-memory model with a fixed access latency and a full req/ack handshake. Serves NUM_PORTS cache-side requesters (I-cache, D-cache, …) one block transaction at a time through round-robin arbitration. Supports block write-back with an optional per-word write mask. Sits below the caches in the pipelined CPU as the simulation backing store.

## Interface
Parameters:
- WORD_W, 16, word width in bits
- BLOCK_WORDS, 4, words per block; power of two, ≥2
- ADDR_W, 8, word-address width; depth = 2^ADDR_W words
- NUM_PORTS, 2, requester count, ≥1
- LATENCY, 4, busy cycles per access, ≥1

Ports (port p occupies slice p; word 0 sits at the LSBs of a block):
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- req  in  NUM_PORTS  request, held until ack
- we  in  NUM_PORTS  1 = block write, 0 = block read
- addr  in  NUM_PORTS*ADDR_W  word address; low log2(BLOCK_WORDS) bits ignored
- wdata  in  NUM_PORTS*BLOCK_WORDS*WORD_W  write block
- wmask  in  NUM_PORTS*BLOCK_WORDS  per-word write enable, used only when BLOCKMEM_WMASK_EN is defined
- rdata  out  NUM_PORTS*BLOCK_WORDS*WORD_W  block returned with ack
- ack  out  NUM_PORTS  one-cycle completion pulse
- busy  out  1  high in BUSY and RESP

## Operation
- FSM states:
  - IDLE: if any req is set, grant the first requesting port at or after rr_ptr (cyclic order). Latch the port id and block-aligned address. If we is set, commit the write on this edge. Set cnt <= LATENCY-1 and go to BUSY.
  - BUSY: if cnt != 0, decrement. If cnt == 0, load the granted port's rdata with the current block contents, set ack[g] <= 1, set rr_ptr <= g+1 (mod NUM_PORTS), and go to RESP.
  - RESP: ack <= 0, go to IDLE.
- A write returns its post-write block contents on rdata, so merged data is visible.
- rdata of non-granted ports holds its last value. Each port's rdata is valid from its ack onward until that port's next ack.
- Requesters must hold we, addr, wdata and wmask stable while req is high. Only the sample taken at grant is used.
- No request queueing: ungranted ports wait with req high. The starvation bound is NUM_PORTS-1 transactions.
- Reset values: state IDLE, ack 0, all rdata 0, rr_ptr 0, cnt 0, busy 0. Memory array is not reset; contents persist across reset.
- Reset during BUSY or RESP aborts the transaction: no ack, and an already committed write remains in memory.
- Addresses wrap modulo 2^ADDR_W; there is no out-of-range case.

## Timing
- Grant at edge t0. ack is high during the cycle after edge t0+LATENCY.
- Turnaround per transaction is LATENCY+2 cycles (grant, LATENCY busy edges, RESP).
- req still high at the RESP→IDLE edge is sampled as a new request at the following IDLE edge. Requesters drop req in the ack cycle.
- Simultaneous req from all ports resolves purely by rr_ptr.

## Configuration
- BLOCKMEM_WMASK_EN defined: on a write, only words whose wmask bit is 1 are updated; a write with wmask all-zero is a read with a write-class grant.
- BLOCKMEM_WMASK_EN undefined: wmask is ignored and every write updates all BLOCK_WORDS words.

## Structure
- Shared package blockmem_pkg holds:
  - the state enum (IDLE/BUSY/RESP)
  - BLOCK_W = BLOCK_WORDS*WORD_W
  - the offset-width constant
  - block pack/unpack helper functions
- Sub-module blockmem_rr_arbiter: combinational NUM_PORTS-way round-robin pick taking req and rr_ptr, producing grant index and valid. rr_ptr update stays in the parent.

## Test plan
- Preload words 0x20..0x23 = 0xA0..0xA3; after reset, port0 reads addr 0x22 → ack0 in the cycle after grant+4 edges, rdata0 = {0xA3,0xA2,0xA1,0xA0}, ack1 never pulses.
- Port1 writes addr 0x41 with wdata {0x4444,0x3333,0x2222,0x1111} and wmask 4'hF → ack1 with rdata1 equal to wdata; a following port0 read of 0x43 returns the same block.
- Both ports request together right after reset → port0 served first, port1 granted at the next IDLE edge; both request again → port1 served first.
- With BLOCKMEM_WMASK_EN, write 0x40 with wmask 4'b0101 over all-zero memory and wdata of all 0xFFFF → block {0,0xFFFF,0,0xFFFF}; without the macro → all four words 0xFFFF.
- Write grant followed by reset_n low two cycles later → no ack, busy 0 after the reset edge, and a later read of that block shows the written data.
- LATENCY=1 with req held back-to-back on port0 → acks every 3 cycles.
